// File: rtl/fnd_pkg.sv
// Shared constants, glyph table, conversion state enum and BCD sizing for the FND scan controller.
package fnd_pkg;

  // Active-low segment glyphs, index = digit value 0..F
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} conv_state_e;

  // Decimal digits needed for the largest unsigned value of width w
  function automatic int bcd_digits(input int w);
    longint m;
    int d;
    m = (longint'(1) << w) - 1;
    d = 1;
    m = m / 10;
    while (m != 0) begin
      d++;
      m = m / 10;
    end
    return d;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential double-dabble: one bit per cycle, DATA_W cycles after start.
module fnd_bin2bcd #(
  parameter int DATA_W = 14,
  parameter int BCD_W  = 4 * fnd_pkg::bcd_digits(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q, bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W/4; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // High during the cycle whose edge performs the final shift
  assign done = active_q && (cnt_q == CNT_W'(DATA_W-1));
  assign bcd  = bcd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      bin_q    <= value;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_q          <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller with decimal/hex conversion, blanking, dp and blink.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     i_value,
  input  logic                  i_valid,
  output logic                  o_busy,
  input  logic                  i_hex_mode,
  input  logic                  i_lz_blank,
  input  logic [NUM_DIGITS-1:0] i_dp_mask,
  input  logic [NUM_DIGITS-1:0] i_blink_mask,
  output logic [NUM_DIGITS-1:0] fnd_com,
  output logic [7:0]            fnd_data
);

  localparam int TICK_DIV  = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
  localparam int TICK_W    = $clog2(TICK_DIV + 1);
  localparam int BLINK_DIV = (SCAN_HZ / 4 > 0) ? SCAN_HZ / 4 : 1;
  localparam int BLINK_W   = $clog2(BLINK_DIV + 1);
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_D     = bcd_digits(DATA_W);
  localparam int BCD_W     = 4 * BCD_D;
  localparam int EXT_W     = 4 * ((NUM_DIGITS > BCD_D) ? NUM_DIGITS : BCD_D);

  logic [TICK_W-1:0]  tick_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [IDX_W-1:0]   idx;
  logic               scan_tick, blink_on;

  conv_state_e state_q, state_d;
  logic [DATA_W-1:0] val_q;
  logic              hex_q, lz_q, conv_start, conv_done;
  logic [BCD_W-1:0]  bcd;
  logic [EXT_W-1:0]  val_ext, bcd_ext;
  logic              dec_ovf, hex_ovf;

  logic [NUM_DIGITS-1:0][3:0] disp_dig;
  logic                       disp_ovf, disp_lz;
  logic [NUM_DIGITS-1:0]      blank;
  logic [7:0]                 seg;
  logic                       hi_zero;

  // Scan timebase, digit index and blink phase
  assign scan_tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      tick_cnt <= scan_tick ? '0 : tick_cnt + 1'b1;
      if (scan_tick) begin
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Conversion FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    case (state_q)
      S_IDLE:
        if (i_valid) begin
          state_d    = i_hex_mode ? S_COMMIT : S_SHIFT;
          conv_start = ~i_hex_mode;
        end
      S_SHIFT:  if (conv_done) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign o_busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      hex_q <= 1'b0;
      lz_q  <= 1'b0;
    end else if (state_q == S_IDLE && i_valid) begin
      val_q <= i_value;
      hex_q <= i_hex_mode;
      lz_q  <= i_lz_blank;
    end
  end

  fnd_bin2bcd #(.DATA_W(DATA_W), .BCD_W(BCD_W)) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(conv_start),
    .value(i_value),
    .done (conv_done),
    .bcd  (bcd)
  );

  assign val_ext = EXT_W'(val_q);
  assign bcd_ext = EXT_W'(bcd);

  // Anything beyond the visible digits means the value does not fit
  always_comb begin
    dec_ovf = 1'b0;
    hex_ovf = 1'b0;
    for (int k = 4*NUM_DIGITS; k < EXT_W; k++) begin
      dec_ovf = dec_ovf | bcd_ext[k];
      hex_ovf = hex_ovf | val_ext[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_dig <= '0;
      disp_ovf <= 1'b0;
      disp_lz  <= 1'b0;
    end else if (state_q == S_COMMIT) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        disp_dig[i] <= hex_q ? val_ext[4*i +: 4] : bcd_ext[4*i +: 4];
      disp_ovf <= hex_q ? hex_ovf : dec_ovf;
      disp_lz  <= lz_q;
    end
  end

  // Digit i is a leading zero if it and every digit above it are zero; digit 0 always shows
  always_comb begin
    hi_zero = 1'b1;
    blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero  = hi_zero && (disp_dig[i] == 4'd0);
      blank[i] = disp_lz && hi_zero && (i != 0);
    end
  end

  always_comb begin
    seg = GLYPH[disp_dig[idx]];
    if (disp_ovf)        seg = SEG_DASH;
    else if (blank[idx]) seg = SEG_BLANK;
    if (i_dp_mask[idx])  seg[7] = 1'b0;
    if (!blink_on && i_blink_mask[idx]) seg = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fnd_com  <= ~NUM_DIGITS'(1);
      fnd_data <= GLYPH[0];
    end else begin
      fnd_com  <= ~(NUM_DIGITS'(1) << idx);
      fnd_data <= seg;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed self-checking bench: 4-digit DUT plus a 3-digit DUT sharing stimulus.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] i_value = '0;
  logic        i_valid = 1'b0, i_hex_mode = 1'b0, i_lz_blank = 1'b0;
  logic [3:0]  i_dp_mask = '0, i_blink_mask = '0;
  logic        o_busy, o_busy3;
  logic [3:0]  fnd_com;
  logic [2:0]  fnd_com3;
  logic [7:0]  fnd_data, fnd_data3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .NUM_DIGITS(4), .DATA_W(14)) dut (
    .clk(clk), .rst(rst), .i_value(i_value), .i_valid(i_valid), .o_busy(o_busy),
    .i_hex_mode(i_hex_mode), .i_lz_blank(i_lz_blank), .i_dp_mask(i_dp_mask),
    .i_blink_mask(i_blink_mask), .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .NUM_DIGITS(3), .DATA_W(14)) dut3 (
    .clk(clk), .rst(rst), .i_value(i_value), .i_valid(i_valid), .o_busy(o_busy3),
    .i_hex_mode(i_hex_mode), .i_lz_blank(i_lz_blank), .i_dp_mask(i_dp_mask[2:0]),
    .i_blink_mask(i_blink_mask[2:0]), .fnd_com(fnd_com3), .fnd_data(fnd_data3)
  );

  // Issue one load; n = cycles o_busy stayed high, mid = fnd_data on busy cycle 8.
  // dup_at != 0 fires a second (hex, value 55) request on that busy cycle.
  task automatic load(input logic [13:0] v, input bit hex, input bit lz, input int dup_at,
                      output int n, output logic [7:0] mid);
    @(negedge clk);
    i_value = v; i_hex_mode = hex; i_lz_blank = lz; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    mid = 8'h00;
    while (o_busy === 1'b1 && n < 200) begin
      n++;
      if (n == 8) mid = fnd_data;
      if (dup_at != 0 && n == dup_at) begin
        i_value = 14'd55; i_hex_mode = 1'b1; i_lz_blank = 1'b1; i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  // Wait (bounded) until digit d is selected and return its segments
  task automatic grab(input bit sel3, input int d, output logic [7:0] seg, output bit ok);
    logic [3:0] want, c;
    want = ~(4'b0001 << d);
    ok = 1'b0;
    seg = 8'h00;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      c = sel3 ? {1'b1, fnd_com3} : fnd_com;
      if (c === want) begin
        ok = 1'b1;
        seg = sel3 ? fnd_data3 : fnd_data;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] s;
    bit ok;
    repeat (2) @(negedge clk);
    checks++; if (fnd_com !== 4'b1110) begin errors++; $display("FAIL rst_com: got %b want 1110", fnd_com); end
    checks++; if (fnd_data !== 8'hC0) begin errors++; $display("FAIL rst_data: got %h want c0", fnd_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    checks++; if (fnd_com3 !== 3'b110) begin errors++; $display("FAIL rst_com3: got %b want 110", fnd_com3); end
    rst = 1'b0;
    grab(1'b0, 1, s, ok);
    checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL rst_d1: got %h want c0", s); end
  endtask

  task automatic test_decimal();
    int n;
    logic [7:0] mid, prev;
    logic [3:0] com_exp [4];
    logic [7:0] dat_exp [4];
    int k;
    com_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    dat_exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    load(14'd1234, 1'b0, 1'b0, 0, n, mid);
    checks++; if (n != 15) begin errors++; $display("FAIL dec_busy: got %0d want 15", n); end
    checks++; if (mid !== 8'hC0) begin errors++; $display("FAIL dec_old_visible: got %h want c0", mid); end
    // align to the cycle digit 0 becomes selected
    prev = 8'h00;
    k = 0;
    while (k < 100 && !(fnd_com === 4'b1110 && prev[3:0] !== 4'b1110)) begin
      prev[3:0] = fnd_com;
      @(negedge clk);
      k++;
    end
    for (int d = 0; d < 4; d++) begin
      checks++; if (fnd_com !== com_exp[d]) begin errors++; $display("FAIL dec_com%0d: got %b want %b", d, fnd_com, com_exp[d]); end
      checks++; if (fnd_data !== dat_exp[d]) begin errors++; $display("FAIL dec_d%0d: got %h want %h", d, fnd_data, dat_exp[d]); end
      repeat (9) @(negedge clk);
      checks++; if (fnd_com !== com_exp[d]) begin errors++; $display("FAIL dec_hold%0d: got %b want %b", d, fnd_com, com_exp[d]); end
      @(negedge clk);
    end
  endtask

  task automatic test_lz_blank();
    int n;
    logic [7:0] mid, s;
    bit ok;
    load(14'd7, 1'b0, 1'b1, 0, n, mid);
    grab(1'b0, 0, s, ok);
    checks++; if (!ok || s !== 8'hF8) begin errors++; $display("FAIL lz7_d0: got %h want f8", s); end
    for (int d = 1; d < 4; d++) begin
      grab(1'b0, d, s, ok);
      checks++; if (!ok || s !== 8'hFF) begin errors++; $display("FAIL lz7_d%0d: got %h want ff", d, s); end
    end
    load(14'd0, 1'b0, 1'b1, 0, n, mid);
    grab(1'b0, 0, s, ok);
    checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL lz0_d0: got %h want c0", s); end
    grab(1'b0, 1, s, ok);
    checks++; if (!ok || s !== 8'hFF) begin errors++; $display("FAIL lz0_d1: got %h want ff", s); end
  endtask

  task automatic test_hex();
    int n;
    logic [7:0] mid, s;
    bit ok;
    logic [7:0] exp [4];
    exp = '{8'h8E, 8'h88, 8'hA4, 8'hC0};
    load(14'h2AF, 1'b1, 1'b0, 0, n, mid);
    checks++; if (n != 1) begin errors++; $display("FAIL hex_busy: got %0d want 1", n); end
    for (int d = 0; d < 4; d++) begin
      grab(1'b0, d, s, ok);
      checks++; if (!ok || s !== exp[d]) begin errors++; $display("FAIL hex_d%0d: got %h want %h", d, s, exp[d]); end
    end
    load(14'h3FFF, 1'b1, 1'b0, 0, n, mid);
    for (int d = 0; d < 3; d++) begin
      grab(1'b1, d, s, ok);
      checks++; if (!ok || s !== 8'hBF) begin errors++; $display("FAIL hex3_ovf_d%0d: got %h want bf", d, s); end
    end
    grab(1'b0, 3, s, ok);
    checks++; if (!ok || s !== 8'hB0) begin errors++; $display("FAIL hex4_d3: got %h want b0", s); end
  endtask

  task automatic test_overflow_busy();
    int n;
    logic [7:0] mid, s;
    bit ok;
    load(14'd10000, 1'b0, 1'b0, 3, n, mid);
    checks++; if (n != 15) begin errors++; $display("FAIL ovf_busy: got %0d want 15", n); end
    repeat (2) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ovf_no_queue: got %b want 0", o_busy); end
    for (int d = 0; d < 4; d++) begin
      grab(1'b0, d, s, ok);
      checks++; if (!ok || s !== 8'hBF) begin errors++; $display("FAIL ovf_d%0d: got %h want bf", d, s); end
    end
  endtask

  task automatic test_dp_blink();
    int n, cyc, last_chg, n_chg, bad_iv, dp_bad, other;
    logic [7:0] mid;
    bit st, prev_st, have_prev;
    load(14'd1234, 1'b0, 1'b0, 0, n, mid);
    i_dp_mask = 4'b0010;
    i_blink_mask = 4'b0001;
    cyc = 0; last_chg = -1; n_chg = 0; bad_iv = 0; dp_bad = 0; other = 0;
    have_prev = 1'b0; prev_st = 1'b0;
    repeat (600) begin
      @(negedge clk);
      cyc++;
      if (fnd_com === 4'b1101 && fnd_data[7] !== 1'b0) dp_bad++;
      if (fnd_com === 4'b1110) begin
        if (fnd_data !== 8'h99 && fnd_data !== 8'hFF) other++;
        st = (fnd_data === 8'hFF);
        if (have_prev && st != prev_st) begin
          // toggle every 25 ticks = 250 cycles; digit 0 is seen once per 40 cycles
          if (last_chg >= 0 && (cyc - last_chg < 210 || cyc - last_chg > 290)) bad_iv++;
          last_chg = cyc;
          n_chg++;
        end
        prev_st = st;
        have_prev = 1'b1;
      end
    end
    checks++; if (dp_bad != 0) begin errors++; $display("FAIL dp_digit1: %0d samples with dp off, want 0", dp_bad); end
    checks++; if (other != 0) begin errors++; $display("FAIL blink_glyph: %0d bad digit0 samples, want 0", other); end
    checks++; if (n_chg < 2) begin errors++; $display("FAIL blink_toggles: got %0d want >=2", n_chg); end
    checks++; if (bad_iv != 0) begin errors++; $display("FAIL blink_period: %0d bad intervals, want 0", bad_iv); end
    i_dp_mask = '0;
    i_blink_mask = '0;
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] s;
    bit ok;
    @(negedge clk);
    i_value = 14'd9999; i_hex_mode = 1'b0; i_lz_blank = 1'b0; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rms_busy_pre: got %b want 1", o_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (fnd_com !== 4'b1110) begin errors++; $display("FAIL rms_com: got %b want 1110", fnd_com); end
    checks++; if (fnd_data !== 8'hC0) begin errors++; $display("FAIL rms_data: got %h want c0", fnd_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rms_busy: got %b want 0", o_busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rms_busy_post: got %b want 0", o_busy); end
    for (int d = 0; d < 4; d++) begin
      grab(1'b0, d, s, ok);
      checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL rms_d%0d: got %h want c0", d, s); end
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_lz_blank();
    test_hex();
    test_overflow_busy();
    test_dp_blink();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the input clock frequency.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, meaning the per-digit scan advance rate.
REQ-003 SHALL have parameter NUM_DIGITS, default 4, legal range 1..8, meaning the number of display digits.
REQ-004 SHALL have parameter DATA_W, default 14, legal range 4..27, meaning the input value width.
REQ-005 SHALL have port clk, input, 1 bit, meaning the system clock.
REQ-006 SHALL have port rst, input, 1 bit, meaning reset; reset rst is asynchronous and active-high; clock clk.
REQ-007 SHALL have port i_value, input, DATA_W bits, meaning the unsigned value to display.
REQ-008 SHALL have port i_valid, input, 1 bit, meaning a load request for i_value and the mode inputs.
REQ-009 SHALL have port o_busy, output, 1 bit, meaning a conversion is in progress and loads are refused.
REQ-010 SHALL have port i_hex_mode, input, 1 bit, meaning 1 = hexadecimal display and 0 = decimal display; sampled with i_valid.
REQ-011 SHALL have port i_lz_blank, input, 1 bit, meaning leading-zero blanking is enabled; sampled with i_valid.
REQ-012 SHALL have port i_dp_mask, input, NUM_DIGITS bits, meaning decimal-point enable per digit; live, not sampled.
REQ-013 SHALL have port i_blink_mask, input, NUM_DIGITS bits, meaning blink enable per digit; live, not sampled.
REQ-014 SHALL have port fnd_com, output, NUM_DIGITS bits, meaning the active-low digit common selects.
REQ-015 SHALL have port fnd_data, output, 8 bits, meaning the active-low segments, where bit7 = dp and bits 6:0 = g..a.

Function
REQ-016 SHALL generate a one-cycle scan tick every CLK_HZ/SCAN_HZ clk cycles from a free-running counter.
REQ-017 SHALL advance the digit index on each scan tick: 0,1,..,NUM_DIGITS-1, then wrap to 0.
REQ-018 SHALL drive fnd_com with exactly one bit low, at the current index; all other bits high.
REQ-019 SHALL implement a conversion FSM with states IDLE, SHIFT and COMMIT.
  - IDLE -> SHIFT when i_valid=1 and decimal mode.
  - IDLE -> COMMIT when i_valid=1 and hex mode.
  - SHIFT -> COMMIT after DATA_W shift cycles.
  - COMMIT -> IDLE unconditionally.
REQ-020 SHALL use sequential double-dabble in SHIFT: one bit per cycle, add-3 to any BCD nibble >= 5 before each shift.
REQ-021 SHALL assert o_busy whenever the FSM is not in IDLE.
  - Decimal load accepted at edge N: o_busy is high for DATA_W+1 cycles, and the display register updates at edge N+DATA_W+1.
  - Hex load: o_busy is high for 1 cycle.
REQ-022 SHALL ignore i_valid while o_busy=1; no queuing, and the sampled value and modes are unchanged.
REQ-023 SHALL keep the previous display register contents visible until COMMIT.
REQ-024 SHALL display overflow as dash (8'hBF) on every digit.
  - Decimal overflow: the value is >= 10^NUM_DIGITS.
  - Hex overflow: any value bit at or above 4*NUM_DIGITS is set.
REQ-025 SHALL use this digit glyph table, digit 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
REQ-026 SHALL apply leading-zero blanking when enabled: digits above the most significant nonzero digit output 8'hFF; digit 0 is never blanked, so value 0 shows "0".
REQ-027 SHALL clear fnd_data[7] when i_dp_mask[index]=1, including on blanked or dash digits.
REQ-028 SHALL toggle the blink phase every SCAN_HZ/4 scan ticks.
  - In the off phase, digits with i_blink_mask set output 8'hFF, and the dp is suppressed too.
REQ-029 SHALL register fnd_com and fnd_data, so each updates one cycle after the scan tick or index change.

Reset
REQ-030 SHALL, on rst, asynchronously return to this state:
  - FSM IDLE, o_busy=0;
  - tick counter 0, digit index 0, blink phase on;
  - display register 0, hex_mode 0, lz_blank 0.
REQ-031 SHALL, while rst is high, drive fnd_com = all ones except bit0 = 0, and fnd_data = 8'hC0.
REQ-032 SHALL, on rst during SHIFT, discard the conversion; the display register is 0 after reset.

Structure
REQ-033 SHALL place the shared items in package fnd_pkg:
  - the glyph table;
  - constants SEG_DASH = 8'hBF and SEG_BLANK = 8'hFF;
  - the FSM state enum;
  - a function giving the BCD digit count for DATA_W.
REQ-034 SHALL implement the double-dabble datapath as sub-module fnd_bin2bcd (start, done, value in, BCD out); scan, blink and segment logic stay in the top level.

Verification (CLK_HZ=1000, SCAN_HZ=100, NUM_DIGITS=4, DATA_W=14)
REQ-035 SHALL check decimal load, i_value=1234, i_valid for 1 cycle:
  - o_busy is high for 15 cycles;
  - digits show 4,3,2,1, with fnd_com 1110,1101,1011,0111 every 10 cycles.
REQ-036 SHALL check lz_blank=1 with value 7: digit 0 = F8, digits 1..3 = FF; with value 0: digit 0 = C0.
REQ-037 SHALL check hex mode with value 0x2AF: digits show 8E,88,A4,C0 and o_busy is high for 1 cycle; value 0x3FFF with NUM_DIGITS=3 shows BF on all digits.
REQ-038 SHALL check decimal value 10000, which shows BF on all digits; a second i_valid during o_busy is ignored, and the display matches the first value.
REQ-039 SHALL check i_dp_mask=0010 with i_blink_mask=0001, run for 60 scan ticks:
  - digit 1 has bit7=0 throughout;
  - digit 0 alternates glyph/FF every 25 scan ticks.
REQ-040 SHALL check rst asserted mid-SHIFT:
  - outputs go to the reset values immediately, and o_busy=0;
  - after release the display shows 0000.
